guess_entry: RTL and testbench

GUESS_ENTRY -- requirements
Module: guess_entry

---
 rtl/guess_entry.sv | 191 +++++++++++++++++++
 tb/tb_guess_entry.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// Colour-code guess entry with cursor, per-slot colour select and
// a small history of committed guesses that can be browsed.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   btn_*               single-cycle debounced button pulses
//   blink_enable        1 = GUESS mode, 0 = HISTORY mode
//   blink_led           cursor slot index 0-3
//   guess_rgb0..3       current guess colour per slot
//   history_rgb0..3     colours of the history entry being viewed
//   hist_count          number of stored guesses
//   hist_full           history holds HIST_DEPTH guesses
//   submit_valid        one-cycle pulse on an accepted submit
//   submit_guess        last committed guess {slot3..slot0}
module guess_entry #(
  parameter int NUM_COLORS = 6,
  parameter int HIST_DEPTH = 8,
  localparam int IW = $clog2(HIST_DEPTH),
  localparam int CW = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_submit,
  input  logic          btn_mode,
  output logic          blink_enable,
  output logic [1:0]    blink_led,
  output logic [2:0]    guess_rgb0,
  output logic [2:0]    guess_rgb1,
  output logic [2:0]    guess_rgb2,
  output logic [2:0]    guess_rgb3,
  output logic [2:0]    history_rgb0,
  output logic [2:0]    history_rgb1,
  output logic [2:0]    history_rgb2,
  output logic [2:0]    history_rgb3,
  output logic [CW-1:0] hist_count,
  output logic          hist_full,
  output logic          submit_valid,
  output logic [11:0]   submit_guess
);

  localparam logic [0:0] S_HIST  = 1'b0;
  localparam logic [0:0] S_GUESS = 1'b1;
  localparam logic [2:0] NC      = 3'(NUM_COLORS);

  logic [0:0]    r_state;
  logic [1:0]    r_cur;
  logic [2:0]    r_slot [4];
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic [IW-1:0] r_view;
  logic [11:0]   r_hist;
  logic          r_sv;
  logic [11:0]   r_sg;
  logic [11:0]   r_mem [HIST_DEPTH];

  logic [0:0]    w_state;
  logic [1:0]    w_cur;
  logic [2:0]    w_slot [4];
  logic [CW-1:0] w_cnt;
  logic [IW-1:0] w_view;
  logic          w_wr;
  logic [11:0]   w_hist;
  logic [11:0]   w_guess;
  logic [2:0]    w_sel;
  logic          w_is_g;
  logic [IW-1:0] w_last;
  logic [IW-1:0] w_widx;

  assign w_is_g  = (r_state == S_GUESS);
  assign w_sel   = r_slot[r_cur];
  assign w_guess = {r_slot[3], r_slot[2],
                    r_slot[1], r_slot[0]};
  // Newest entry; low bits of a full count
  // wrap to 0 and minus one gives depth-1.
  assign w_last  = r_cnt[IW-1:0] - IW'(1);
  assign w_widx  = r_cnt[IW-1:0];

  // Buttons are taken in strict priority;
  // lower-priority pulses in the same cycle
  // are dropped.
  always_comb begin
    w_state = r_state;
    w_cur   = r_cur;
    w_slot  = r_slot;
    w_cnt   = r_cnt;
    w_view  = r_view;
    w_wr    = 1'b0;
    if (btn_mode) begin
      if (!w_is_g) begin
        w_state = S_GUESS;
      end else if (r_cnt != '0) begin
        w_state = S_HIST;
        w_view  = w_last;
      end
    end else if (btn_submit) begin
      if (w_is_g && !r_full) begin
        w_wr  = 1'b1;
        w_cnt = r_cnt + CW'(1);
      end
    end else if (btn_left) begin
      if (w_is_g) begin
        w_cur = r_cur - 2'd1;
      end else if (r_view != '0) begin
        w_view = r_view - IW'(1);
      end
    end else if (btn_right) begin
      if (w_is_g) begin
        w_cur = r_cur + 2'd1;
      end else if (r_view != w_last) begin
        w_view = r_view + IW'(1);
      end
    end else if (btn_up) begin
      if (w_is_g) begin
        if (w_sel >= NC)
          w_slot[r_cur] = 3'd1;
        else
          w_slot[r_cur] = w_sel + 3'd1;
      end
    end else if (btn_down) begin
      if (w_is_g) begin
        if (w_sel <= 3'd1 || w_sel > NC)
          w_slot[r_cur] = NC;
        else
          w_slot[r_cur] = w_sel - 3'd1;
      end
    end
  end

  // The viewed entry is registered, so a
  // write landing on it must bypass memory.
  always_comb begin
    w_hist = r_mem[w_view];
    if (w_cnt == '0)
      w_hist = '0;
    else if (w_wr && (w_widx == w_view))
      w_hist = w_guess;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_GUESS;
      r_cur   <= 2'd0;
      for (int i = 0; i < 4; i++)
        r_slot[i] <= 3'd1;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_view  <= '0;
      r_hist  <= '0;
      r_sv    <= 1'b0;
      r_sg    <= '0;
    end else begin
      r_state <= w_state;
      r_cur   <= w_cur;
      r_slot  <= w_slot;
      r_cnt   <= w_cnt;
      r_full  <= (w_cnt == CW'(HIST_DEPTH));
      r_view  <= w_view;
      r_hist  <= w_hist;
      r_sv    <= w_wr;
      if (w_wr)
        r_sg <= w_guess;
    end
  end

  // Contents are never cleared; hist_count
  // gates what is visible.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[w_widx] <= w_guess;
  end

  assign blink_enable = (r_state == S_GUESS);
  assign blink_led    = r_cur;
  assign guess_rgb0   = r_slot[0];
  assign guess_rgb1   = r_slot[1];
  assign guess_rgb2   = r_slot[2];
  assign guess_rgb3   = r_slot[3];
  assign history_rgb0 = r_hist[2:0];
  assign history_rgb1 = r_hist[5:3];
  assign history_rgb2 = r_hist[8:6];
  assign history_rgb3 = r_hist[11:9];
  assign hist_count   = r_cnt;
  assign hist_full    = r_full;
  assign submit_valid = r_sv;
  assign submit_guess = r_sg;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed scenarios plus random
// button traffic checked against a queued reference model.
module tb_guess_entry;

  localparam int NC = 6;
  localparam int HD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_l = 0, b_r = 0, b_u = 0;
  logic b_d = 0, b_s = 0, b_m = 0;
  logic       be;
  logic [1:0] led;
  logic [2:0] g0, g1, g2, g3;
  logic [2:0] h0, h1, h2, h3;
  logic [3:0] cnt;
  logic       full;
  logic       sv;
  logic [11:0] sg;

  always #5 clk = ~clk;

  guess_entry #(
    .NUM_COLORS(NC),
    .HIST_DEPTH(HD)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_left(b_l), .btn_right(b_r),
    .btn_up(b_u), .btn_down(b_d),
    .btn_submit(b_s), .btn_mode(b_m),
    .blink_enable(be), .blink_led(led),
    .guess_rgb0(g0), .guess_rgb1(g1),
    .guess_rgb2(g2), .guess_rgb3(g3),
    .history_rgb0(h0), .history_rgb1(h1),
    .history_rgb2(h2), .history_rgb3(h3),
    .hist_count(cnt), .hist_full(full),
    .submit_valid(sv), .submit_guess(sg)
  );

  typedef struct packed {
    logic        be;
    logic [1:0]  led;
    logic [11:0] g;
    logic [11:0] h;
    logic [3:0]  cnt;
    logic        full;
    logic        sv;
    logic [11:0] sg;
  } exp_t;

  exp_t sbq [$];
  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic        m_g;
  int          m_cur;
  int          m_slot [4];
  int          m_cnt;
  int          m_view;
  logic [11:0] m_mem [HD];
  logic        m_sv;
  logic [11:0] m_sg;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [11:0] m_guess();
    return {3'(m_slot[3]), 3'(m_slot[2]),
            3'(m_slot[1]), 3'(m_slot[0])};
  endfunction

  task automatic model_reset();
    m_g = 1; m_cur = 0; m_cnt = 0;
    m_view = 0; m_sv = 0; m_sg = '0;
    for (int i = 0; i < 4; i++) m_slot[i] = 1;
  endtask

  // b = {mode,submit,left,right,up,down}
  task automatic model_step(input logic [5:0] b);
    m_sv = 0;
    if (b[5]) begin
      if (!m_g) m_g = 1;
      else if (m_cnt > 0) begin
        m_g = 0; m_view = m_cnt - 1;
      end
    end else if (b[4]) begin
      if (m_g && m_cnt < HD) begin
        m_mem[m_cnt] = m_guess();
        m_sg = m_guess();
        m_cnt++; m_sv = 1;
      end
    end else if (b[3]) begin
      if (m_g) m_cur = (m_cur == 0) ? 3 : m_cur - 1;
      else if (m_view > 0) m_view--;
    end else if (b[2]) begin
      if (m_g) m_cur = (m_cur == 3) ? 0 : m_cur + 1;
      else if (m_view < m_cnt - 1) m_view++;
    end else if (b[1]) begin
      if (m_g)
        m_slot[m_cur] = (m_slot[m_cur] == NC) ?
                        1 : m_slot[m_cur] + 1;
    end else if (b[0]) begin
      if (m_g)
        m_slot[m_cur] = (m_slot[m_cur] == 1) ?
                        NC : m_slot[m_cur] - 1;
    end
  endtask

  function automatic exp_t mk_exp();
    exp_t e;
    e.be   = m_g;
    e.led  = 2'(m_cur);
    e.g    = m_guess();
    e.h    = (m_cnt == 0) ? 12'h0 : m_mem[m_view];
    e.cnt  = 4'(m_cnt);
    e.full = (m_cnt == HD);
    e.sv   = m_sv;
    e.sg   = m_sg;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sbq_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk("blink_enable", 32'(be), 32'(e.be));
    chk("blink_led", 32'(led), 32'(e.led));
    chk("guess_rgb", 32'({g3, g2, g1, g0}), 32'(e.g));
    chk("history_rgb", 32'({h3, h2, h1, h0}), 32'(e.h));
    chk("hist_count", 32'(cnt), 32'(e.cnt));
    chk("hist_full", 32'(full), 32'(e.full));
    chk("submit_valid", 32'(sv), 32'(e.sv));
    chk("submit_guess", 32'(sg), 32'(e.sg));
  endtask

  task automatic press(input logic [5:0] b);
    @(negedge clk);
    {b_m, b_s, b_l, b_r, b_u, b_d} = b;
    model_step(b);
    sbq.push_back(mk_exp());
    @(posedge clk);
    #1;
    {b_m, b_s, b_l, b_r, b_u, b_d} = '0;
    compare_out();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_be"}, 32'(be), 1);
    chk({tag, "_led"}, 32'(led), 0);
    chk({tag, "_g"}, 32'({g3, g2, g1, g0}), 32'h249);
    chk({tag, "_h"}, 32'({h3, h2, h1, h0}), 0);
    chk({tag, "_cnt"}, 32'(cnt), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_sv"}, 32'(sv), 0);
    chk({tag, "_sg"}, 32'(sg), 0);
  endtask

  localparam logic [5:0] MODE = 6'b100000;
  localparam logic [5:0] SUB  = 6'b010000;
  localparam logic [5:0] LEFT = 6'b001000;
  localparam logic [5:0] RGHT = 6'b000100;
  localparam logic [5:0] UP   = 6'b000010;
  localparam logic [5:0] DOWN = 6'b000001;

  initial begin
    logic [2:0] seq [6];
    logic [5:0] b;
    seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    model_reset();
    #22;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;

    press(MODE);
    chk("mode_empty", 32'(be), 1);

    press(LEFT);
    chk("led_wrap", 32'(led), 3);
    press(RGHT);
    press(RGHT);
    chk("led_right2", 32'(led), 1);
    press(LEFT);

    for (int i = 0; i < 6; i++) begin
      press(UP);
      chk("up_seq", 32'(g0), 32'(seq[i]));
    end
    press(DOWN);
    chk("down_wrap", 32'(g0), 6);

    press(UP);
    press(RGHT); press(UP);
    press(RGHT); press(UP); press(UP);
    press(RGHT); press(UP); press(UP); press(UP);
    press(SUB);
    chk("sub_pulse", 32'(sv), 1);
    chk("sub_guess", 32'(sg), 32'o4321);
    chk("sub_cnt", 32'(cnt), 1);
    press(6'b0);
    chk("sub_once", 32'(sv), 0);
    chk("sub_hold", 32'(sg), 32'o4321);

    press(DOWN); press(SUB);
    press(DOWN); press(SUB);
    chk("cnt3", 32'(cnt), 3);

    press(MODE);
    chk("hist_be", 32'(be), 0);
    chk("hist_new", 32'({h3, h2, h1, h0}), 32'o2321);
    press(RGHT);
    chk("hist_sat_hi", 32'({h3, h2, h1, h0}), 32'o2321);
    press(UP); press(SUB); press(DOWN);
    press(LEFT); press(LEFT); press(LEFT);
    chk("hist_sat_lo", 32'({h3, h2, h1, h0}), 32'o4321);
    press(MODE);
    chk("back_be", 32'(be), 1);
    chk("back_led", 32'(led), 3);

    press(MODE | UP);
    chk("prio_be", 32'(be), 0);
    chk("prio_g", 32'({g3, g2, g1, g0}), 32'o2321);
    press(MODE);

    for (int i = 0; i < 5; i++) press(SUB);
    chk("full", 32'(full), 1);
    press(SUB);
    chk("full_nopulse", 32'(sv), 0);
    chk("full_cnt", 32'(cnt), 8);

    press(MODE);
    press(LEFT);
    #2;
    rst = 1'b1;
    b_u = 1'b1;
    #1;
    chk_reset("async");
    @(posedge clk);
    #1;
    b_r = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_r = 1'b0;
    b_u = 1'b0;
    model_reset();
    chk_reset("rst_rel");
    press(6'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        b = 6'(1 << $urandom_range(0, 5));
      else
        b = 6'($urandom_range(0, 63));
      press(b);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
